// File: rtl/uart_reg_pkg.sv
// ---------------------------------------------------------------------------
// uart_reg_pkg
// Shared constants for the UART register responder: FSM state encoding,
// command opcodes, reply codes and a saturating counter helper.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_reg_pkg;

    // FSM state encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_RD     = 3'd4;
    localparam logic [2:0] S_RDWAIT = 3'd5;
    localparam logic [2:0] S_SEND   = 3'd6;

    // Command opcodes
    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'

    // Reply codes
    localparam logic [7:0] REPLY_ACK = 8'h06;
    localparam logic [7:0] REPLY_NAK = 8'h15;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [7:0] satInc8(input logic [7:0] val);
        return (val == 8'hFF) ? 8'hFF : val + 8'd1;
    endfunction

endpackage

// File: rtl/uart_reg_responder_if.sv
// ---------------------------------------------------------------------------
// uart_reg_responder_if
// Bundles the UART codec byte handshake and the local register bus seen by
// the responder.
//   Byte receive : ARecvData, ARecvAck           (codec -> responder)
//   Byte send    : ASendData, ASendReq, ASendRdy (responder <-> codec)
//   Register bus : AAddr, AWrData, AWrStrb, ARdStrb (responder -> regs)
//                  ARdData, ARdVld                  (regs -> responder)
// Modports: slave = responder side, master = codec/register side.
// ---------------------------------------------------------------------------
interface uart_reg_responder_if;

    logic [7:0] ARecvData;
    logic       ARecvAck;
    logic [7:0] ASendData;
    logic       ASendReq;
    logic       ASendRdy;
    logic [7:0] AAddr;
    logic [7:0] AWrData;
    logic       AWrStrb;
    logic       ARdStrb;
    logic [7:0] ARdData;
    logic       ARdVld;

    modport slave (
        input  ARecvData, ARecvAck, ASendRdy, ARdData, ARdVld,
        output ASendData, ASendReq, AAddr, AWrData, AWrStrb, ARdStrb
    );

    modport master (
        output ARecvData, ARecvAck, ASendRdy, ARdData, ARdVld,
        input  ASendData, ASendReq, AAddr, AWrData, AWrStrb, ARdStrb
    );

endinterface

// File: rtl/uart_reg_tmr.sv
// ---------------------------------------------------------------------------
// uart_reg_tmr
// Enabled-cycle counter shared by the inter-byte timeout and the read-wait
// timeout of the responder.
//   AClkH, AResetN : clock, asynchronous active-low reset
//   AClkHEn        : clock enable; counter only moves when 1
//   ACntClr        : clear to zero (wins over increment)
//   ACntInc        : count one enabled cycle
//   ALimit         : number of counted cycles that constitutes expiry
//   AHit           : the cycle being counted now is the ALimit-th one
// ---------------------------------------------------------------------------
module uart_reg_tmr #(
    parameter int CWidth = 16
) (
    input  logic              AClkH,
    input  logic              AResetN,
    input  logic              AClkHEn,
    input  logic              ACntClr,
    input  logic              ACntInc,
    input  logic [CWidth-1:0] ALimit,
    output logic              AHit
);

    logic [CWidth-1:0] cnt;

    // Hit is flagged on the cycle that would make the count reach ALimit,
    // so expiry lands on exactly the ALimit-th counted cycle.
    assign AHit = (cnt == ALimit - CWidth'(1));

    always_ff @(posedge AClkH or negedge AResetN) begin
        if (!AResetN) begin
            cnt <= '0;
        end else if (AClkHEn) begin
            if (ACntClr) begin
                cnt <= '0;
            end else if (ACntInc) begin
                cnt <= cnt + CWidth'(1);
            end
        end
    end

endmodule

// File: rtl/uart_reg_responder.sv
// ---------------------------------------------------------------------------
// uart_reg_responder
// Slave end of a host-driven UART debug/config link. Decodes byte commands
//   'W' addr data -> register write, reply ACK
//   'R' addr      -> register read,  reply read data (NAK on read timeout)
//   other opcode  -> reply NAK, error pulse
// and returns exactly one reply byte per command.
//   AClkH, AResetN : clock, asynchronous active-low reset
//   AClkHEn        : clock enable for all state and input sampling
//   ABus           : byte handshake + register bus (slave modport)
//   AErr           : one-enabled-cycle error pulse
//   AErrCnt        : saturating count of error pulses
// ---------------------------------------------------------------------------
module uart_reg_responder
    import uart_reg_pkg::*;
#(
    parameter int                     CTimeoutLen = 16,
    parameter logic [CTimeoutLen-1:0] CTimeoutVal = 16'hFFFF,
    parameter logic [3:0]             CRdWait     = 4'hF
) (
    input  logic                  AClkH,
    input  logic                  AResetN,
    input  logic                  AClkHEn,
    uart_reg_responder_if.slave   ABus,
    output logic                  AErr,
    output logic [7:0]            AErrCnt
);

    logic [2:0] state;
    logic       isWrite;
    logic [7:0] addrReg;
    logic [7:0] wrDataReg;
    logic [7:0] replyReg;

    logic inCmd;       // collecting address/data bytes
    logic canAccept;   // a byte offered now will be taken
    logic overrun;
    logic badOp;
    logic cntInc;
    logic cntClr;
    logic cntHit;
    logic expire;
    logic errNow;
    logic [CTimeoutLen-1:0] cntLimit;

    assign inCmd     = (state == S_ADDR) || (state == S_DATA);
    assign canAccept = (state == S_IDLE) || inCmd;
    assign overrun   = ABus.ARecvAck && !canAccept;
    assign badOp     = (state == S_IDLE) && ABus.ARecvAck &&
                       (ABus.ARecvData != OP_WRITE) && (ABus.ARecvData != OP_READ);

    // One counter serves both timeouts; only one of them can be live.
    assign cntLimit = (state == S_RDWAIT) ? CTimeoutLen'(CRdWait) : CTimeoutVal;
    assign cntInc   = (inCmd && !ABus.ARecvAck) || ((state == S_RDWAIT) && !ABus.ARdVld);
    assign expire   = cntInc && cntHit;
    assign cntClr   = (state == S_IDLE) || (state == S_RD) ||
                      (inCmd && ABus.ARecvAck) || expire;

    // Coincident sources merge into a single pulse and a single increment.
    assign errNow = overrun || badOp || expire;

    uart_reg_tmr #(
        .CWidth (CTimeoutLen)
    ) uTmr (
        .AClkH   (AClkH),
        .AResetN (AResetN),
        .AClkHEn (AClkHEn),
        .ACntClr (cntClr),
        .ACntInc (cntInc),
        .ALimit  (cntLimit),
        .AHit    (cntHit)
    );

    always_ff @(posedge AClkH or negedge AResetN) begin
        if (!AResetN) begin
            state     <= S_IDLE;
            isWrite   <= 1'b0;
            addrReg   <= '0;
            wrDataReg <= '0;
            replyReg  <= '0;
            AErr      <= 1'b0;
            AErrCnt   <= '0;
        end else if (AClkHEn) begin
            AErr <= errNow;
            if (errNow) begin
                AErrCnt <= satInc8(AErrCnt);
            end

            case (state)
                S_IDLE: begin
                    if (ABus.ARecvAck) begin
                        if (badOp) begin
                            replyReg <= REPLY_NAK;
                            state    <= S_SEND;
                        end else begin
                            isWrite <= (ABus.ARecvData == OP_WRITE);
                            state   <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    // An arriving byte beats a coincident timeout.
                    if (ABus.ARecvAck) begin
                        addrReg <= ABus.ARecvData;
                        state   <= isWrite ? S_DATA : S_RD;
                    end else if (expire) begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (ABus.ARecvAck) begin
                        wrDataReg <= ABus.ARecvData;
                        state     <= S_WR;
                    end else if (expire) begin
                        state <= S_IDLE;
                    end
                end
                S_WR: begin
                    replyReg <= REPLY_ACK;
                    state    <= S_SEND;
                end
                S_RD: begin
                    state <= S_RDWAIT;
                end
                S_RDWAIT: begin
                    if (ABus.ARdVld) begin
                        replyReg <= ABus.ARdData;
                        state    <= S_SEND;
                    end else if (expire) begin
                        replyReg <= REPLY_NAK;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (ABus.ASendRdy) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes and request are decoded from state so each lasts exactly one
    // enabled cycle (or the whole SEND residency for the request).
    assign ABus.AWrStrb   = (state == S_WR);
    assign ABus.ARdStrb   = (state == S_RD);
    assign ABus.ASendReq  = (state == S_SEND);
    assign ABus.ASendData = replyReg;
    assign ABus.AAddr     = addrReg;
    assign ABus.AWrData   = wrDataReg;

endmodule

// File: tb/tb_uart_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_reg_responder
// Directed bench for uart_reg_responder (inter-byte timeout shortened to 40).
// ---------------------------------------------------------------------------
module tb_uart_reg_responder;

    logic       AClkH;
    logic       AResetN;
    logic       AClkHEn;
    logic       AErr;
    logic [7:0] AErrCnt;

    uart_reg_responder_if bus ();

    uart_reg_responder #(
        .CTimeoutVal (16'd40)
    ) dut (
        .AClkH   (AClkH),
        .AResetN (AResetN),
        .AClkHEn (AClkHEn),
        .ABus    (bus),
        .AErr    (AErr),
        .AErrCnt (AErrCnt)
    );

    initial AClkH = 1'b0;
    always #5 AClkH = ~AClkH;

    int nAsserts = 0;
    int nFails   = 0;
    int wrCnt    = 0;
    int rdCnt    = 0;
    int errPulse = 0;
    logic [7:0] lastWrAddr = 8'h00;
    logic [7:0] lastWrData = 8'h00;

    // Event monitors: count strobes and error pulses per enabled cycle
    always @(posedge AClkH) begin
        if (AClkHEn) begin
            if (bus.AWrStrb) begin
                wrCnt      <= wrCnt + 1;
                lastWrAddr <= bus.AAddr;
                lastWrData <= bus.AWrData;
            end
            if (bus.ARdStrb) rdCnt <= rdCnt + 1;
            if (AErr) errPulse <= errPulse + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required end before 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge AClkH);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.ARecvData = b;
        bus.ARecvAck  = 1'b1;
        tick();
        bus.ARecvAck  = 1'b0;
    endtask

    int n;
    int w0, r0, e0;
    logic [7:0] holdData;

    initial begin
        AResetN       = 1'b0;
        AClkHEn       = 1'b1;
        bus.ARecvData = 8'h00;
        bus.ARecvAck  = 1'b0;
        bus.ASendRdy  = 1'b1;
        bus.ARdData   = 8'h00;
        bus.ARdVld    = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_sendreq", bus.ASendReq, 0);
        check("rst_senddata", bus.ASendData, 0);
        check("rst_addr", bus.AAddr, 0);
        check("rst_wrdata", bus.AWrData, 0);
        check("rst_strobes", {bus.AWrStrb, bus.ARdStrb}, 0);
        check("rst_err", {AErr, AErrCnt}, 0);
        AResetN = 1'b1;
        tick();

        // Write 0x57 0x12 0x5A
        sendByte(8'h57); sendByte(8'h12); sendByte(8'h5A);
        check("wr_strb", bus.AWrStrb, 1);
        check("wr_addr", bus.AAddr, 8'h12);
        check("wr_data", bus.AWrData, 8'h5A);
        check("wr_noreq_yet", bus.ASendReq, 0);
        tick();
        check("wr_strb_off", bus.AWrStrb, 0);
        check("wr_req", bus.ASendReq, 1);
        check("wr_ack", bus.ASendData, 8'h06);
        tick();
        check("wr_req_off", bus.ASendReq, 0);
        check("wr_count", wrCnt, 1);
        check("wr_errcnt", AErrCnt, 0);

        // Read 0x52 0x34, data valid three enabled cycles after strobe
        sendByte(8'h52); sendByte(8'h34);
        check("rd_strb", bus.ARdStrb, 1);
        check("rd_addr", bus.AAddr, 8'h34);
        tick(); tick();
        check("rd_wait_noreq", bus.ASendReq, 0);
        bus.ARdData = 8'hC3;
        bus.ARdVld  = 1'b1;
        tick();
        bus.ARdVld  = 1'b0;
        check("rd_req", bus.ASendReq, 1);
        check("rd_data", bus.ASendData, 8'hC3);
        tick();
        check("rd_count", rdCnt, 1);
        check("rd_errcnt", AErrCnt, 0);

        // Bad opcode
        w0 = wrCnt; r0 = rdCnt; e0 = errPulse;
        sendByte(8'h41);
        check("bad_req", bus.ASendReq, 1);
        check("bad_nak", bus.ASendData, 8'h15);
        check("bad_err", AErr, 1);
        check("bad_errcnt", AErrCnt, 1);
        tick();
        check("bad_err_off", AErr, 0);
        check("bad_pulses", errPulse - e0, 1);
        check("bad_nostrb", (wrCnt - w0) + (rdCnt - r0), 0);

        // Inter-byte timeout after 0x57 0x12
        w0 = wrCnt; e0 = errPulse;
        sendByte(8'h57); sendByte(8'h12);
        for (int i = 0; i < 39; i++) tick();
        check("to_before", AErr, 0);
        tick();
        check("to_err", AErr, 1);
        check("to_errcnt", AErrCnt, 2);
        tick(); tick();
        check("to_nostrb", wrCnt - w0, 0);
        check("to_noreq", bus.ASendReq, 0);
        sendByte(8'h52); sendByte(8'h34);
        check("to_rd_strb", bus.ARdStrb, 1);
        bus.ARdData = 8'h7E;
        bus.ARdVld  = 1'b1;
        tick(); tick();
        bus.ARdVld  = 1'b0;
        check("to_rd_req", bus.ASendReq, 1);
        check("to_rd_data", bus.ASendData, 8'h7E);
        tick();
        check("to_pulses", errPulse - e0, 1);

        // Read wait timeout, then backpressure with an overrun byte
        bus.ASendRdy = 1'b0;
        e0 = errPulse;
        sendByte(8'h52); sendByte(8'h34);
        n = 0;
        while (!bus.ASendReq && n < 40) begin
            tick();
            n++;
        end
        check("rdto_latency", n, 16);
        check("rdto_nak", bus.ASendData, 8'h15);
        check("rdto_err", AErr, 1);
        check("rdto_errcnt", AErrCnt, 3);
        holdData = bus.ASendData;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                bus.ARecvData = 8'h57;
                bus.ARecvAck  = 1'b1;
            end
            tick();
            bus.ARecvAck = 1'b0;
            check("bp_req", bus.ASendReq, 1);
            check("bp_data", bus.ASendData, holdData);
        end
        check("ovr_pulses", errPulse - e0, 2);
        check("ovr_errcnt", AErrCnt, 4);
        bus.ASendRdy = 1'b1;
        tick();
        check("bp_release", bus.ASendReq, 0);
        w0 = wrCnt;
        sendByte(8'h57); sendByte(8'hAA); sendByte(8'h55);
        tick(); tick();
        check("ovr_wr_count", wrCnt - w0, 1);
        check("ovr_wr_addr", lastWrAddr, 8'hAA);
        check("ovr_wr_data", lastWrData, 8'h55);

        // Clock enable held low mid-command
        w0 = wrCnt;
        sendByte(8'h57); sendByte(8'h21);
        AClkHEn       = 1'b0;
        bus.ARecvData = 8'h99;
        bus.ARecvAck  = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.ARecvAck  = 1'b0;
        check("ce_addr_hold", bus.AAddr, 8'h21);
        check("ce_nostrb", wrCnt - w0, 0);
        check("ce_noreq", bus.ASendReq, 0);
        AClkHEn = 1'b1;
        sendByte(8'h33);
        check("ce_strb", bus.AWrStrb, 1);
        check("ce_wrdata", bus.AWrData, 8'h33);
        tick();
        check("ce_ack", bus.ASendData, 8'h06);
        tick();
        check("ce_errcnt", AErrCnt, 4);

        // Error count saturation
        for (int i = 0; i < 260; i++) begin
            sendByte(8'h41);
            tick();
        end
        check("sat_errcnt", AErrCnt, 8'hFF);

        // Reset while in DATA
        w0 = wrCnt;
        sendByte(8'h57); sendByte(8'h44);
        AResetN       = 1'b0;
        bus.ARecvData = 8'h66;
        bus.ARecvAck  = 1'b1;
        #2;
        check("mrst_addr", bus.AAddr, 0);
        check("mrst_wrdata", bus.AWrData, 0);
        check("mrst_send", {bus.ASendReq, bus.ASendData}, 0);
        check("mrst_err", {AErr, AErrCnt}, 0);
        tick(); tick();
        bus.ARecvAck = 1'b0;
        AResetN      = 1'b1;
        tick(); tick(); tick();
        check("mrst_nostrb", wrCnt - w0, 0);
        check("mrst_noreq", bus.ASendReq, 0);
        sendByte(8'h57); sendByte(8'h01); sendByte(8'h02);
        check("mrst_wr_strb", bus.AWrStrb, 1);
        check("mrst_wr_addr", bus.AAddr, 8'h01);
        tick(); tick();
        check("mrst_wr_count", wrCnt - w0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
- Byte-level command responder for the far side of the UART codec byte interface.
- Consumes received bytes (ARecvData/ARecvAck), decodes a fixed read/write command protocol, drives a simple 8-bit register bus, and returns one reply byte per command through ASendData/ASendReq/ASendRdy.
- Sits between the UART codec and local peripheral registers as the slave end of a host-driven debug/config link.

Parameters:
- CTimeoutLen, 16, width of inter-byte timeout counter.
- CTimeoutVal, 16'hFFFF, enabled cycles allowed between bytes of one command.
- CRdWait, 4'hF, enabled cycles allowed for ARdVld after ARdStrb.

Ports:
- AClkH  in  1  clock.
- AResetN  in  1  asynchronous active-low reset.
- AClkHEn  in  1  clock enable; all state advances and all input sampling only when 1.
- ARecvData  in  8  received byte, valid when ARecvAck=1.
- ARecvAck  in  1  byte received; counted once per enabled cycle.
- ASendData  out  8  reply byte.
- ASendReq  out  1  reply request.
- ASendRdy  in  1  transmitter idle.
- AAddr  out  8  bus address.
- AWrData  out  8  bus write data.
- AWrStrb  out  1  write strobe, one enabled cycle.
- ARdStrb  out  1  read strobe, one enabled cycle.
- ARdData  in  8  read data, valid with ARdVld.
- ARdVld  in  1  read data valid.
- AErr  out  1  error pulse, one enabled cycle.
- AErrCnt  out  8  saturating error count.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0. Reset mid-command aborts with no strobe and no reply.
- Protocol:
  - 'W'=0x57, addr, data -> bus write, reply ACK 0x06.
  - 'R'=0x52, addr -> bus read, reply read data.
  - Any other opcode -> reply NAK 0x15, AErr.
- Byte accept: the byte is taken in an enabled cycle with ARecvAck=1, and only in IDLE/ADDR/DATA.
- Overrun: a byte accepted in WR/RD/RDWAIT/SEND is dropped and pulses AErr. The current command is unaffected.
- FSM states and transitions:
  - IDLE: on 'W' or 'R', latch the opcode and go to ADDR. On another opcode, load NAK and go to SEND with AErr.
  - ADDR: on a byte, latch AAddr. Go to DATA if the opcode is W, else to RD.
  - DATA: on a byte, latch AWrData and go to WR.
  - WR: AWrStrb=1 for one enabled cycle; load ACK; go to SEND.
  - RD: ARdStrb=1 for one enabled cycle; clear the wait counter; go to RDWAIT.
  - RDWAIT: if ARdVld=1, latch ARdData as the reply and go to SEND. Otherwise, once CRdWait enabled cycles have elapsed, load NAK, pulse AErr, and go to SEND.
- SEND:
  - ASendReq=1 with ASendData stable until an enabled cycle where ASendRdy=1; then ASendReq=0 next cycle and the FSM returns to IDLE.
  - ASendRdy=1 on entry is accepted in the first SEND cycle.
- Latency (N = enabled cycle of the last command byte):
  - Write: AWrStrb at N+1; ASendReq from N+2.
  - Read: ARdStrb at N+1; ARdVld sampled from N+2; ASendReq in the cycle after ARdVld.
- Timeout:
  - In ADDR/DATA, the counter increments on each enabled cycle without a byte and clears on each accepted byte.
  - When it reaches CTimeoutVal: return to IDLE, pulse AErr, no strobe, no reply.
  - A byte arriving in the same cycle as expiry is accepted; the byte takes priority.
- AErrCnt increments on every AErr pulse and saturates at 0xFF. Simultaneous error sources give one increment.
- AAddr/AWrData hold their last values between commands.

Decomposition:
- Package uart_reg_pkg holds:
  - state encoding;
  - opcode constants 0x57/0x52;
  - ACK 0x06, NAK 0x15.
- Sub-module: none required. Optionally split out a timeout/wait counter block, uart_reg_tmr.

Test Plan:
- Write: bytes 0x57, 0x12, 0x5A -> one AWrStrb with AAddr=0x12, AWrData=0x5A; ASendReq with 0x06; AErrCnt=0.
- Read: bytes 0x52, 0x34; ARdVld with 0xC3 three enabled cycles after ARdStrb -> exactly one ARdStrb; reply 0xC3.
- Bad opcode: byte 0x41 -> reply 0x15; one AErr pulse; AErrCnt=1; no strobes.
- Timeouts:
  - 0x57, 0x12 followed by CTimeoutVal idle enabled cycles -> no AWrStrb, AErr, return to IDLE; a following 0x52, 0x34 read completes normally.
  - 0x52, 0x34 with ARdVld never asserted -> NAK 0x15 after CRdWait cycles; AErr pulses once.
- Overrun and backpressure:
  - Byte 0x57 arriving during SEND -> dropped, AErr pulses.
  - ASendRdy held low for 50 cycles -> ASendReq/ASendData stable throughout.
- Clock enable and reset:
  - AClkHEn=0 for 10 cycles mid-command -> no state change.
  - AResetN pulsed in DATA -> all outputs 0, no write strobe.
